joy_db15_tx: RTL and testbench

- Responder end of the SNAC DB15 serial joystick link; models the adapter-side parallel-in/serial-out shift chain that the core's DB15 reader polls via JOY_LOAD/JOY_CLK/JOY_DATA.
- Latches two 12-bit active-low player words on LOAD and shifts them out one bit per JOY_CLK rising edge.
- Used as a loopback source for bench and bring-up, and as the USER_IN[5] driver when a second board emulates a pad.
- Runs in the 53.6 MHz core domain; JOY_CLK and JOY_LOAD are asynchronous and oversampled.

---
 rtl/joy_db15_pkg.sv | 31 +++
 rtl/joy_db15_sync_edge.sv | 60 ++++++
 rtl/joy_db15_tx.sv | 125 ++++++++++++
 tb/tb_joy_db15_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg: shared constants and types for the DB15 serial joystick responder.
//   JOY_DB15_NBITS  - default frame length (P1 bits 0..11, then P2 bits 0..11)
//   JOY_DB15_PAD_W  - width of one player word
//   JB_*            - bit positions inside a player word (active-low buttons)
//   tx_state_t      - responder FSM states
package joy_db15_pkg;

   localparam int unsigned JOY_DB15_NBITS = 24;
   localparam int unsigned JOY_DB15_PAD_W = 12;

   localparam int unsigned JB_R          = 0;
   localparam int unsigned JB_L          = 1;
   localparam int unsigned JB_D          = 2;
   localparam int unsigned JB_U          = 3;
   localparam int unsigned JB_A          = 4;
   localparam int unsigned JB_B          = 5;
   localparam int unsigned JB_C          = 6;
   localparam int unsigned JB_D_BTN      = 7;
   localparam int unsigned JB_E          = 8;
   localparam int unsigned JB_F          = 9;
   localparam int unsigned JB_START      = 10;
   localparam int unsigned JB_L_SHOULDER = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/joy_db15_sync_edge.sv
// joy_db15_sync_edge: synchroniser + optional glitch filter + rise detector for
// one asynchronous control pin. All flops preset to 1 (idle-high pins).
//   clk_i   - core clock
//   rst_ni  - asynchronous active-low reset
//   async_i - asynchronous pin
//   level_o - synchronised (and optionally filtered) level
//   rise_o  - one-cycle pulse on a 0->1 transition of level_o
// Macro JOY_DB15_TX_GLITCH_FILTER_EN inserts a 3-sample majority filter after
// the synchroniser (rejects 1-cycle pulses, adds 2 cycles of latency).
module joy_db15_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              level;
   logic              prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
      end
   end

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
   logic [2:0] hist_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hist_q <= '1;
      end else begin
         hist_q <= {hist_q[1:0], sync_q[STAGES-1]};
      end
   end

   assign level = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                  (hist_q[1] & hist_q[2]);
`else
   assign level = sync_q[STAGES-1];
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level;
      end
   end

   assign level_o = level;
   assign rise_o  = level & ~prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: responder end of the SNAC DB15 serial joystick link. Emulates the
// adapter's parallel-in/serial-out chain: JOY_LOAD low latches {pad2,pad1},
// each JOY_CLK rise shifts one bit out on JOY_DATA (LSB of pad1 first).
//   i_clk      - core clock
//   RESETn     - asynchronous active-low reset
//   JOY_CLK    - async shift clock from reader (rising edge advances)
//   JOY_LOAD   - async parallel load from reader, active low
//   JOY_DATA   - serial data to reader (registered shreg[0])
//   pad1/pad2  - active-low player words
//   busy       - frame latched and not fully shifted
//   frame_done - one-cycle pulse once the last frame bit has been shifted past
//   bit_idx    - index of the bit currently on JOY_DATA (0..NBITS)
// Optional macro: JOY_DB15_TX_GLITCH_FILTER_EN (majority filter on both pins).
module joy_db15_tx
   import joy_db15_pkg::*;
#(
   parameter int unsigned NBITS       = JOY_DB15_NBITS,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        FILL_BIT    = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      RESETn,
   input  logic                      JOY_CLK,
   input  logic                      JOY_LOAD,
   output logic                      JOY_DATA,
   input  logic [JOY_DB15_PAD_W-1:0] pad1,
   input  logic [JOY_DB15_PAD_W-1:0] pad2,
   output logic                      busy,
   output logic                      frame_done,
   output logic [4:0]                bit_idx
);

   if (NBITS > 31) begin : g_nbits_chk
      $error("joy_db15_tx: NBITS must be <= 31");
   end
   if (SYNC_STAGES < 2) begin : g_sync_chk
      $error("joy_db15_tx: SYNC_STAGES must be >= 2");
   end

   localparam logic [4:0] LAST_IDX = 5'(NBITS);

   logic clk_rise;
   logic clk_lvl_unused;
   logic load_lvl;
   logic load_rise;

   joy_db15_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
      .clk_i   (i_clk),
      .rst_ni  (RESETn),
      .async_i (JOY_CLK),
      .level_o (clk_lvl_unused),
      .rise_o  (clk_rise)
   );

   joy_db15_sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
      .clk_i   (i_clk),
      .rst_ni  (RESETn),
      .async_i (JOY_LOAD),
      .level_o (load_lvl),
      .rise_o  (load_rise)
   );

   tx_state_t        state_q, state_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic [4:0]       idx_q,   idx_d;
   logic             done_q,  done_d;

   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= IDLE;
         shreg_q <= '1;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Load dominates everything (74x165 behaviour): while synced LOAD is low the
   // pads are re-latched every cycle and clock rises are dropped, including the
   // rise that coincides with LOAD release (state is still LOAD that cycle).
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      if (!load_lvl) begin
         state_d = LOAD;
         shreg_d = NBITS'({pad2, pad1});
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
            end
            LOAD: begin
               if (load_rise) begin
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (clk_rise) begin
                  shreg_d = {FILL_BIT, shreg_q[NBITS-1:1]};
                  idx_d   = idx_q + 5'd1;
                  if (idx_q + 5'd1 == LAST_IDX) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            DONE: begin
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign JOY_DATA   = shreg_q[0];
   assign busy       = (state_q == SHIFT);
   assign frame_done = done_q;
   assign bit_idx    = idx_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed self-checking bench for joy_db15_tx.
module tb_joy_db15_tx;

   logic        clk;
   logic        rst_n;
   logic        joy_clk;
   logic        joy_load;
   logic        joy_data;
   logic [11:0] pad1;
   logic [11:0] pad2;
   logic        busy;
   logic        frame_done;
   logic [4:0]  bit_idx;

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
   localparam int LAT = 5;
   localparam int GLITCH_SHIFT = 0;
`else
   localparam int LAT = 3;
   localparam int GLITCH_SHIFT = 1;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   joy_db15_tx #(.NBITS(24), .SYNC_STAGES(2), .FILL_BIT(1'b1)) dut (
      .i_clk      (clk),
      .RESETn     (rst_n),
      .JOY_CLK    (joy_clk),
      .JOY_LOAD   (joy_load),
      .JOY_DATA   (joy_data),
      .pad1       (pad1),
      .pad2       (pad2),
      .busy       (busy),
      .frame_done (frame_done),
      .bit_idx    (bit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clk();
      joy_clk = 1'b1;
      cyc(4);
      joy_clk = 1'b0;
      cyc(4);
   endtask

   task automatic do_load();
      joy_load = 1'b0;
      cyc(6);
      joy_load = 1'b1;
      cyc(8);
   endtask

   // Sample the bit on JOY_DATA before each of the 24 rises.
   task automatic run_frame(output logic [23:0] word);
      for (int i = 0; i < 24; i++) begin
         word[i] = joy_data;
         pulse_clk();
      end
   endtask

   initial begin
      logic [23:0] word;
      int          d0;
      int          n;

      rst_n    = 1'b0;
      joy_clk  = 1'b0;
      joy_load = 1'b1;
      pad1     = 12'hFFF;
      pad2     = 12'hFFF;
      cyc(3);

      chk("rst_data", {31'd0, joy_data}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
      chk("rst_idx", {27'd0, bit_idx}, 32'd0);
      rst_n = 1'b1;
      cyc(4);

      // Load and full shift
      pad1 = 12'hFFE;
      pad2 = 12'hFFF;
      do_load();
      chk("t1_data0", {31'd0, joy_data}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_idx0", {27'd0, bit_idx}, 32'd0);
      d0 = done_cnt;
      run_frame(word);
      chk("t1_word", {8'd0, word}, 32'h00FFFFFE);
      chk("t1_done_cnt", done_cnt - d0, 32'd1);
      chk("t1_busy_after", {31'd0, busy}, 32'd0);
      chk("t1_idx_end", {27'd0, bit_idx}, 32'd24);
      pulse_clk();
      chk("t1_data_after", {31'd0, joy_data}, 32'd1);

      // Bit order
      pad1 = 12'h5A5;
      pad2 = 12'h3C3;
      do_load();
      d0 = done_cnt;
      run_frame(word);
      chk("t2_word", {8'd0, word}, 32'h003C35A5);
      chk("t2_done_cnt", done_cnt - d0, 32'd1);

      // Abort mid-frame
      do_load();
      d0 = done_cnt;
      for (int i = 0; i < 10; i++) pulse_clk();
      chk("t3_idx10", {27'd0, bit_idx}, 32'd10);
      chk("t3_busy_mid", {31'd0, busy}, 32'd1);
      pad1 = 12'h000;
      do_load();
      chk("t3_no_done", done_cnt - d0, 32'd0);
      chk("t3_idx0", {27'd0, bit_idx}, 32'd0);
      chk("t3_data0", {31'd0, joy_data}, 32'd0);
      d0 = done_cnt;
      run_frame(word);
      chk("t3_word", {8'd0, word}, 32'h003C3000);
      chk("t3_done_cnt", done_cnt - d0, 32'd1);

      // Clock during load, then clock rise coincident with load release
      pad1 = 12'h001;
      joy_load = 1'b0;
      cyc(6);
      for (int i = 0; i < 5; i++) pulse_clk();
      chk("t4_idx", {27'd0, bit_idx}, 32'd0);
      chk("t4_data", {31'd0, joy_data}, 32'd1);
      joy_load = 1'b1;
      joy_clk  = 1'b1;
      cyc(8);
      chk("t4_rel_idx", {27'd0, bit_idx}, 32'd0);
      chk("t4_rel_data", {31'd0, joy_data}, 32'd1);
      chk("t4_rel_busy", {31'd0, busy}, 32'd1);
      joy_clk = 1'b0;
      cyc(4);

      // Overclock: 30 rises
      pad1 = 12'h000;
      pad2 = 12'h000;
      do_load();
      d0 = done_cnt;
      for (int i = 1; i <= 30; i++) begin
         pulse_clk();
         if (i >= 24) begin
            chk($sformatf("t5_idx_r%0d", i), {27'd0, bit_idx}, 32'd24);
            chk($sformatf("t5_data_r%0d", i), {31'd0, joy_data}, 32'd1);
         end
      end
      chk("t5_done_cnt", done_cnt - d0, 32'd1);
      chk("t5_busy", {31'd0, busy}, 32'd0);

      // Latency: pin rise to JOY_DATA change
      pad1 = 12'h002;
      pad2 = 12'hFFF;
      do_load();
      chk("t6_data_pre", {31'd0, joy_data}, 32'd0);
      joy_clk = 1'b1;
      n = 0;
      while (n < 10 && joy_data == 1'b0) begin
         cyc(1);
         n++;
      end
      chk("t6_latency", n, LAT);
      cyc(4);
      joy_clk = 1'b0;
      cyc(8);
      chk("t6_idx1", {27'd0, bit_idx}, 32'd1);

      // Single-cycle glitch on JOY_CLK
      joy_clk = 1'b1;
      cyc(1);
      joy_clk = 1'b0;
      cyc(8);
      chk("t7_glitch_idx", {27'd0, bit_idx}, 32'd1 + GLITCH_SHIFT);
`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
      pulse_clk();
`endif
      chk("t7_data_pre_rst", {31'd0, joy_data}, 32'd0);

      // Asynchronous reset mid-frame
      #3;
      rst_n = 1'b0;
      #1;
      chk("t8_rst_data", {31'd0, joy_data}, 32'd1);
      chk("t8_rst_busy", {31'd0, busy}, 32'd0);
      chk("t8_rst_idx", {27'd0, bit_idx}, 32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      pulse_clk();
      pulse_clk();
      chk("t8_post_idx", {27'd0, bit_idx}, 32'd0);
      chk("t8_post_busy", {31'd0, busy}, 32'd0);
      chk("t8_post_data", {31'd0, joy_data}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
